segment_capture: RTL and testbench

- Receive-side decoder for the multiplexed 7-segment bus: monitors the active-low anode select and active-low segment lines, and reconstructs the four displayed BCD digits.
- Lets the bench and on-board self-check compare what the display is actually showing against the stopwatch counters.
- Sits passively alongside the display driver's outputs and only observes them; it never drives the bus.

---
 rtl/segment_capture.sv | 174 +++++++++++++++++
 tb/tb_segment_capture.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_capture.sv
// Passive decoder for the multiplexed 7-segment bus.
// Optional blink detection: define SEGMENT_CAPTURE_BLINK_DETECT_EN.
module segment_capture #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] an,
  input  logic [7:0] segment,
  output logic [3:0] s0,
  output logic [3:0] s1,
  output logic [3:0] m0,
  output logic [3:0] m1,
  output logic [3:0] digit_valid,
  output logic [3:0] blank_mask,
  output logic [3:0] dp,
  output logic       frame_done,
  output logic       err,
  output logic       blinking
);

  localparam logic [7:0] SETTLE = 8'(SETTLE_CYCLES);

  logic [11:0] prev;
  logic [11:0] sample;
  logic [7:0]  cnt;
  logic [7:0]  cnt_nxt;
  logic        captured;
  logic        flag_cur;
  logic        strobe;
  logic        cap;
  logic [3:0]  pos;
  logic [3:0]  seen;
  logic [3:0]  seen_nxt;
  logic [3:0]  dec_val;
  logic        dec_ok;
  logic        is_blank;
  logic [3:0]  dig [4];

  assign sample = {an, segment};

  // A changed sample restarts the window; a held one saturates.
  always_comb begin
    cnt_nxt  = 8'd1;
    flag_cur = 1'b0;
    if (sample == prev) begin
      cnt_nxt  = (cnt >= SETTLE) ? SETTLE : cnt + 8'd1;
      flag_cur = captured;
    end
  end

  assign strobe   = (cnt_nxt == SETTLE) && !flag_cur;
  assign cap      = strobe && (pos != 4'b0000);
  assign seen_nxt = seen | pos;
  assign is_blank = (segment[6:0] == 7'h7F);

  always_comb begin
    pos = 4'b0000;
    unique case (an)
      4'b1110: pos = 4'b0001;
      4'b1101: pos = 4'b0010;
      4'b1011: pos = 4'b0100;
      4'b0111: pos = 4'b1000;
      default: pos = 4'b0000;
    endcase
  end

  always_comb begin
    dec_ok  = 1'b1;
    dec_val = 4'd0;
    unique case (segment[6:0])
      7'h40:   dec_val = 4'd0;
      7'h79:   dec_val = 4'd1;
      7'h24:   dec_val = 4'd2;
      7'h30:   dec_val = 4'd3;
      7'h19:   dec_val = 4'd4;
      7'h12:   dec_val = 4'd5;
      7'h02:   dec_val = 4'd6;
      7'h78:   dec_val = 4'd7;
      7'h00:   dec_val = 4'd8;
      7'h10:   dec_val = 4'd9;
      default: dec_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev        <= 12'hFFF;
      cnt         <= '0;
      captured    <= 1'b0;
      seen        <= '0;
      digit_valid <= '0;
      blank_mask  <= '0;
      dp          <= '0;
      frame_done  <= 1'b0;
      err         <= 1'b0;
      for (int i = 0; i < 4; i++) dig[i] <= '0;
    end else begin
      prev       <= sample;
      cnt        <= cnt_nxt;
      captured   <= flag_cur | strobe;
      frame_done <= 1'b0;
      err        <= 1'b0;
      if (cap) begin
        for (int i = 0; i < 4; i++) begin
          if (pos[i]) begin
            dp[i] <= ~segment[7];
            if (dec_ok) begin
              dig[i]         <= dec_val;
              digit_valid[i] <= 1'b1;
              blank_mask[i]  <= 1'b0;
            end else begin
              digit_valid[i] <= 1'b0;
              blank_mask[i]  <= is_blank;
            end
          end
        end
        err <= !dec_ok && !is_blank;
        if (seen_nxt == 4'b1111) begin
          frame_done <= 1'b1;
          seen       <= '0;
        end else begin
          seen <= seen_nxt;
        end
      end
    end
  end

  assign s0 = dig[0];
  assign s1 = dig[1];
  assign m0 = dig[2];
  assign m1 = dig[3];

`ifdef SEGMENT_CAPTURE_BLINK_DETECT_EN
  typedef enum logic [1:0] {
    CLS_MIXED,
    CLS_BLANK,
    CLS_VALID
  } cls_t;

  cls_t cur_cls;
  cls_t last_cls;

  always_comb begin
    cur_cls = CLS_MIXED;
    if (&blank_mask)       cur_cls = CLS_BLANK;
    else if (&digit_valid) cur_cls = CLS_VALID;
  end

  // Classify the frame one cycle after frame_done, once masks settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_cls <= CLS_MIXED;
      blinking <= 1'b0;
    end else if (frame_done) begin
      last_cls <= cur_cls;
      unique case (cur_cls)
        CLS_MIXED: blinking <= 1'b0;
        CLS_VALID: begin
          if (last_cls == CLS_VALID)      blinking <= 1'b0;
          else if (last_cls == CLS_BLANK) blinking <= 1'b1;
        end
        CLS_BLANK: begin
          if (last_cls == CLS_VALID) blinking <= 1'b1;
        end
        default: blinking <= blinking;
      endcase
    end
  end
`else
  assign blinking = 1'b0;
`endif

endmodule

// File: tb/tb_segment_capture.sv
// Scoreboard bench for segment_capture with a run-length reference model.
module tb_segment_capture;

  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] an = 4'hF;
  logic [7:0] segment = 8'hFF;
  logic [3:0] s0, s1, m0, m1, digit_valid, blank_mask, dp;
  logic       frame_done, err, blinking;

  segment_capture #(.SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .an(an), .segment(segment),
    .s0(s0), .s1(s1), .m0(m0), .m1(m1),
    .digit_valid(digit_valid), .blank_mask(blank_mask), .dp(dp),
    .frame_done(frame_done), .err(err), .blinking(blinking)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] m1, m0, s1, s0;
    logic [3:0] dv, bm, dp;
    logic       fd, er, bl;
  } obs_t;

  obs_t expq[$];
  int   checks = 0;
  int   fails = 0;

  // Reference model state
  int   dig[4];
  bit   val[4], blk[4], dpb[4];
  bit   seen[4];
  bit   fd_m, er_m, bl_m;
  bit   have_run;
  int   run_len;
  logic [11:0] run_val;
  bit   pend;
  int   pend_cls, last_cls;
  logic [6:0] codes [10];

  initial begin
    codes[0] = 7'h40; codes[1] = 7'h79; codes[2] = 7'h24; codes[3] = 7'h30;
    codes[4] = 7'h19; codes[5] = 7'h12; codes[6] = 7'h02; codes[7] = 7'h78;
    codes[8] = 7'h00; codes[9] = 7'h10;
  end

  function automatic obs_t pack_model();
    obs_t o;
    o.s0 = 4'(dig[0]); o.s1 = 4'(dig[1]);
    o.m0 = 4'(dig[2]); o.m1 = 4'(dig[3]);
    for (int i = 0; i < 4; i++) begin
      o.dv[i] = val[i]; o.bm[i] = blk[i]; o.dp[i] = dpb[i];
    end
    o.fd = fd_m; o.er = er_m; o.bl = bl_m;
    return o;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      dig[i] = 0; val[i] = 0; blk[i] = 0; dpb[i] = 0; seen[i] = 0;
    end
    fd_m = 0; er_m = 0; bl_m = 0;
    have_run = 0; run_len = 0; pend = 0; last_cls = 0;
  endtask

  task automatic capture(input int p, input logic [7:0] sg);
    int d;
    bit all_b, all_v, all_s;
    d = -1;
    for (int k = 0; k < 10; k++) if (codes[k] == sg[6:0]) d = k;
    if (d >= 0) begin
      dig[p] = d; val[p] = 1; blk[p] = 0;
    end else if (sg[6:0] == 7'h7F) begin
      val[p] = 0; blk[p] = 1;
    end else begin
      val[p] = 0; blk[p] = 0; er_m = 1;
    end
    dpb[p] = ~sg[7];
    seen[p] = 1;
    all_s = seen[0] & seen[1] & seen[2] & seen[3];
    if (all_s) begin
      fd_m = 1;
      for (int i = 0; i < 4; i++) seen[i] = 0;
      all_b = blk[0] & blk[1] & blk[2] & blk[3];
      all_v = val[0] & val[1] & val[2] & val[3];
      pend = 1;
      pend_cls = all_b ? 1 : (all_v ? 2 : 0);
    end
  endtask

  // cls: 0 mixed, 1 all blank, 2 all valid
  task automatic apply_blink(input int cls);
`ifdef SEGMENT_CAPTURE_BLINK_DETECT_EN
    if (cls == 0) bl_m = 0;
    else if (cls == 2 && last_cls == 2) bl_m = 0;
    else if (last_cls != 0 && cls != last_cls) bl_m = 1;
`endif
    last_cls = cls;
  endtask

  task automatic model_edge();
    int p;
    logic [11:0] v;
    if (!rst_n) begin
      model_reset();
    end else begin
      fd_m = 0; er_m = 0;
      if (pend) begin
        pend = 0;
        apply_blink(pend_cls);
      end
      v = {an, segment};
      if (have_run && v == run_val) run_len++;
      else begin
        run_val = v; run_len = 1; have_run = 1;
      end
      if (run_len == S) begin
        case (an)
          4'b1110: p = 0;
          4'b1101: p = 1;
          4'b1011: p = 2;
          4'b0111: p = 3;
          default: p = -1;
        endcase
        if (p >= 0) capture(p, segment);
      end
    end
    expq.push_back(pack_model());
  endtask

  task automatic step(input logic [3:0] a, input logic [7:0] s, input int n);
    for (int i = 0; i < n; i++) begin
      an = a; segment = s;
      @(posedge clk);
      model_edge();
      #1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 0;
    #1;
    checks++;
    if ({s0, s1, m0, m1, digit_valid, blank_mask, dp, frame_done, err} !== '0) begin
      fails++;
      $display("FAIL async_reset got=%h required=0",
               {s0, s1, m0, m1, digit_valid, blank_mask, dp, frame_done, err});
    end
    @(posedge clk);
    model_edge();
    #1;
    rst_n = 1;
  endtask

  task automatic frame(input bit blank);
    step(4'b1110, blank ? 8'hFF : 8'hC0, 5);
    step(4'b1101, blank ? 8'hFF : 8'hF9, 5);
    step(4'b1011, blank ? 8'hFF : 8'hA4, 5);
    step(4'b0111, blank ? 8'hFF : 8'hB0, 5);
  endtask

  // Monitor: compare each presented output state with the scoreboard head
  initial begin
    obs_t e, g;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        g = {m1, m0, s1, s0, digit_valid, blank_mask, dp, frame_done, err, blinking};
        checks++;
        if (g !== e) begin
          fails++;
          $display("FAIL outputs t=%0t got=%h required=%h", $time, g, e);
        end
      end
    end
  end

  initial begin
    logic [7:0] sg;
    logic [3:0] a;
    model_reset();
    repeat (2) begin
      @(posedge clk);
      model_edge();
    end
    #1;
    rst_n = 1;

    for (int i = 0; i < 6; i++) step(4'b1110, i[0] ? 8'hF9 : 8'hC0, 3);
    step(4'b1110, 8'hFF, 6);
    step(4'b1110, 8'hC0, 8);
    frame(0);
    step(4'b1101, 8'hAA, 4);
    step(4'b1111, 8'hC0, 10);
    step(4'b1110, 8'h40, 6);
    step(4'b1101, 8'h79, 6);
    step(4'b1011, 8'h24, 6);
    do_reset();
    frame(0);
    frame(1);
    frame(0);
    frame(0);
    frame(1);
    step(4'b1110, 8'h99, 6);
    frame(0);

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(9) < 7)
        a = 4'b1111 ^ (4'b0001 << $urandom_range(3));
      else
        a = 4'($urandom);
      case ($urandom_range(9))
        0, 1, 2, 3, 4, 5: begin
          sg[6:0] = codes[$urandom_range(9)];
          sg[7] = 1'($urandom);
        end
        6: sg = {1'($urandom), 7'h7F};
        default: sg = 8'($urandom);
      endcase
      step(a, sg, int'($urandom_range(7, 1)));
      if (n == 120) do_reset();
    end
    step(4'b1111, 8'hFF, 2);

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    checks++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
